fifo_rd_stream: RTL and testbench

Read-side adapter that drains a synchronous FIFO (registered read data, one-cycle read latency, registered `empty` flag) and presents its contents as a valid/ready stream. It sits directly downstream of the `fifo` block and converts its pull-style `rd_en`/`data_out` port into a backpressure-safe push stream. It never loses or duplicates a word when `m_ready` deasserts mid-burst, and it sustains one word per cycle. A flush input and a handshake counter support drain and debug.

---
 rtl/fifo_rd_stream.sv | 131 +++++++++++++
 tb/tb_fifo_rd_stream.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream
//
// Read-side adapter between a synchronous FIFO and a valid/ready stream. The
// FIFO has registered read data, a one-cycle read latency and a registered
// empty flag. A two-entry buffer absorbs the read latency, so words are never
// lost or duplicated when m_ready drops in the middle of a burst. With
// m_ready held high the adapter moves one word per cycle.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active high
//   fifo_empty  upstream FIFO empty flag (registered in the FIFO)
//   fifo_data   upstream FIFO read data, valid the cycle after a read
//   fifo_rd_en  read request to the upstream FIFO (combinational)
//   flush       discards all buffered and in-flight words
//   m_data      stream data (always slot0)
//   m_valid     stream valid
//   m_ready     stream accept from downstream
//   xfer_count  completed handshakes, modulo 2^CNT_WIDTH
// ---------------------------------------------------------------------------
module fifo_rd_stream #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_data,
  output logic                 fifo_rd_en,
  input  logic                 flush,
  output logic [WIDTH-1:0]     m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [CNT_WIDTH-1:0] xfer_count
);

  // Registered state
  logic [WIDTH-1:0]     slot0_q, slot0_d;
  logic [WIDTH-1:0]     slot1_q, slot1_d;
  logic [1:0]           occ_q, occ_d;
  logic                 inflight_q, inflight_d;
  logic                 drop_q, drop_d;
  logic [CNT_WIDTH-1:0] xfer_count_q, xfer_count_d;

  // Combinational helpers
  logic       pop_s;
  logic       capture_s;
  logic [2:0] budget_s;
  logic [1:0] occ_after_pop_s;
  logic       rd_en_s;

  // Handshake, capture qualification and read-issue decision.
  always_comb begin
    pop_s     = (occ_q != 2'd0) & m_ready;
    // A returning word is discarded when a flush is active in the cycle it
    // arrives, or when the drop flag from an earlier flush is still set.
    capture_s = inflight_q & ~drop_q & ~flush;
    // Slots that would be committed after this cycle's pop, counting the
    // word already in flight. A new read is allowed while that stays below
    // two, which guarantees the returning word always has a free slot.
    budget_s  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    rd_en_s   = ~rst & ~flush & ~fifo_empty & (budget_s < 3'd2);
  end

  // Buffer update: pop shifts slot1 into slot0 first, then the returned word
  // lands in the lowest free slot after that shift.
  always_comb begin
    slot0_d         = slot0_q;
    slot1_d         = slot1_q;
    occ_after_pop_s = occ_q - {1'b0, pop_s};

    if (pop_s) begin
      slot0_d = slot1_q;
    end else begin
      slot0_d = slot0_q;
    end

    if (capture_s) begin
      if (occ_after_pop_s == 2'd0) begin
        slot0_d = fifo_data;
      end else begin
        slot1_d = fifo_data;
      end
    end else begin
      slot1_d = slot1_d;
    end

    if (flush) begin
      occ_d = 2'd0;
    end else begin
      occ_d = occ_after_pop_s + {1'b0, capture_s};
    end
  end

  // Read tracking, flush drop flag and handshake counter.
  always_comb begin
    inflight_d   = rd_en_s;
    drop_d       = flush & inflight_q;
    xfer_count_d = xfer_count_q + {{(CNT_WIDTH-1){1'b0}}, pop_s};
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot0_q      <= '0;
      slot1_q      <= '0;
      occ_q        <= 2'd0;
      inflight_q   <= 1'b0;
      drop_q       <= 1'b0;
      xfer_count_q <= '0;
    end else begin
      slot0_q      <= slot0_d;
      slot1_q      <= slot1_d;
      occ_q        <= occ_d;
      inflight_q   <= inflight_d;
      drop_q       <= drop_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  // Output mapping: stream side comes straight from registers; the read
  // request stays combinational so a returning m_ready can refill at once.
  always_comb begin
    m_data     = slot0_q;
    m_valid    = (occ_q != 2'd0);
    xfer_count = xfer_count_q;
    fifo_rd_en = rd_en_s;
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst, flush, m_ready, fifo_empty;
  logic [7:0] fifo_data, m_data;
  logic       fifo_rd_en, m_valid;
  logic [3:0] xfer_count;

  always #5 clk = ~clk;

  fifo_rd_stream #(.WIDTH(8), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .flush(flush), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .xfer_count(xfer_count)
  );

  typedef struct { logic [7:0] d; int avail; } ent_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         cnt = 0;
  ent_t       exp_q[$];
  logic [7:0] fq[$];
  bit         started = 1'b0;
  bit         rst_prev = 1'b0;
  int         rd_hi, hs_n, first_hs, last_hs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // One clock cycle: apply inputs, check against the reference model,
  // advance the model and the upstream FIFO to the next edge.
  task automatic step(input logic r, input logic f, input logic rdy,
                      input logic w, input logic [7:0] wd);
    bit         ev, hs, er, rd_acc;
    logic [7:0] word;
    int         outst;
    rst = r; flush = f; m_ready = rdy;
    #3;
    word  = 8'h00;
    ev    = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
    hs    = ev && rdy && !r;
    outst = exp_q.size() - (hs ? 1 : 0);
    er    = !r && !f && !fifo_empty && (outst < 2);
    check("rd_en", {31'd0, fifo_rd_en}, {31'd0, er});
    if (started) begin
      check("m_valid", {31'd0, m_valid}, {31'd0, ev});
      check("xfer_count", {28'd0, xfer_count}, 32'(cnt & 15));
      if (ev) check("m_data", {24'd0, m_data}, {24'd0, exp_q[0].d});
      if (rst_prev) check("m_data_rst", {24'd0, m_data}, 32'd0);
      check("occ_inflight_le2",
            {31'd0, (({1'b0, dut.occ_q} + {2'b00, dut.inflight_q}) <= 3'd2)}, 32'd1);
    end
    rd_acc = (fifo_rd_en === 1'b1) && !fifo_empty;
    if (rd_acc) word = fq.pop_front();
    if (r) begin
      exp_q.delete();
      fq.delete();
      cnt = 0;
    end else begin
      if (hs) begin
        void'(exp_q.pop_front());
        cnt++;
        hs_n++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      if (f) exp_q.delete();
      if (rd_acc) exp_q.push_back('{word, cyc + 2});
      if (w) fq.push_back(wd);
    end
    if (fifo_rd_en === 1'b1) rd_hi++;
    rst_prev = r;
    if (r) started = 1'b1;
    @(posedge clk);
    #1;
    if (r) fifo_data = 8'h00;
    else if (rd_acc) fifo_data = word;
    fifo_empty = (fq.size() == 0);
    cyc++;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
    fifo_empty = 1'b1; fifo_data = 8'h00;
    rd_hi = 0; hs_n = 0; first_hs = -1; last_hs = 0;

    // Reset and basic drain of 0x11, 0x22, 0x33
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check("reset_valid", {31'd0, m_valid}, 32'd0);
    check("reset_count", {28'd0, xfer_count}, 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h11);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h22);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h33);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check("drain_count", {28'd0, xfer_count}, 32'd3);

    // Backpressure: 8 words, m_ready pattern 1,0,0
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'(i));
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, (i % 3) == 0, 1'b0, 8'h00);
    check("bp_count", {28'd0, xfer_count}, 32'd11);

    // Full throughput: fill 8 words while flush holds reads off, then drain
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 8'(8'h40 + i));
    rd_hi = 0; hs_n = 0; first_hs = -1;
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check("tp_rd_cycles", 32'(rd_hi), 32'd8);
    check("tp_handshakes", 32'(hs_n), 32'd8);
    check("tp_consecutive", 32'(last_hs - first_hs), 32'd7);

    // Flush with a read in flight
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'(8'h80 + i));
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check("pre_flush_inflight", {31'd0, dut.inflight_q}, 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("flush_valid", {31'd0, m_valid}, 32'd0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

    // Counter wrap: exactly 17 handshakes after reset on a 4-bit counter
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'(8'hA0 + i));
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check("wrap_count", {28'd0, xfer_count}, 32'd1);

    // Randomised traffic with occasional flush
    for (int i = 0; i < 250; i++) begin
      step(1'b0, ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
           (fq.size() < 8) && ($urandom_range(0, 2) != 0), 8'($urandom));
    end

    // Reset in the middle of a sustained stream
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'(8'hC0 + i));
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'hEE);
    check("midrst_valid", {31'd0, m_valid}, 32'd0);
    check("midrst_data", {24'd0, m_data}, 32'd0);
    check("midrst_count", {28'd0, xfer_count}, 32'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, (i < 4), 8'(8'hD0 + i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
